// File: rtl/moore_seq_detector_pkg.sv
// Shared types and defaults for the programmable
// Moore sequence detector.
package moore_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    MATCH = 2'b10,
    ERROR = 2'b11
  } state_t;

  localparam int unsigned CODE_W_DEF  = 8;
  localparam int unsigned DEPTH_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF = 16;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// Code-word stream, table programming and result
// bundle between source, detector and consumer.
interface moore_seq_detector_if
  import moore_seq_pkg::*;
#(
  parameter int unsigned CODE_W = CODE_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
);

  localparam int unsigned AW = idx_w(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH + 1);

  logic              clear;
  logic [CODE_W-1:0] in_code;
  logic              in_valid;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [CODE_W-1:0] cfg_data;
  logic              len_we;
  logic [PW-1:0]     len_data;
  state_t            state;
  logic [PW-1:0]     progress;
  logic              match;
  logic              error;
  logic              timeout;

  modport master (
    output clear, in_code, in_valid,
    output cfg_we, cfg_addr, cfg_data,
    output len_we, len_data,
    input  state, progress,
    input  match, error, timeout
  );

  modport slave (
    input  clear, in_code, in_valid,
    input  cfg_we, cfg_addr, cfg_data,
    input  len_we, len_data,
    output state, progress,
    output match, error, timeout
  );

endinterface

// File: rtl/seq_timeout_counter.sv
// Idle-cycle counter that flags when a partial
// sequence has waited TIMEOUT cycles.
module seq_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst, run, restart};
    assign expire    = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Fires on the edge that would bring the count to TIMEOUT.
    assign expire = run && !restart
                 && (cnt_q == CW'(TIMEOUT - 1));

    // Count idle cycles; any restart or leaving TRACK zeroes it.
    always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!run || restart || expire)
        cnt_d = '0;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/moore_seq_detector.sv
// Programmable Moore sequence detector: code table,
// length register and registered match/error FSM.
module moore_seq_detector
  import moore_seq_pkg::*;
#(
  parameter int unsigned CODE_W          = CODE_W_DEF,
  parameter int unsigned DEPTH           = DEPTH_DEF,
  parameter int unsigned TIMEOUT         = TIMEOUT_DEF,
  parameter bit          RESTART_ON_MISS = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  moore_seq_detector_if.slave  bus
);

  localparam int unsigned AW = idx_w(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH + 1);

  logic [CODE_W-1:0] tbl_q [DEPTH];
  logic [PW-1:0]     len_q;

  state_t        state_q, state_d;
  logic [PW-1:0] prog_q, prog_d;
  logic          match_q, error_q;
  logic          tout_q, tout_d;

  logic          cfg_ok;
  logic          hit, hit0;
  logic          expire;
  logic          tmr_run, tmr_restart;
  logic [PW-1:0] prog_inc;
  logic [AW-1:0] idx;
  logic          len_ok;
  logic          addr_ok;

  assign cfg_ok   = (state_q == IDLE);
  assign idx      = prog_q[AW-1:0];
  assign hit      = (bus.in_code == tbl_q[idx]);
  assign hit0     = (bus.in_code == tbl_q[0]);
  assign prog_inc = prog_q + PW'(1);
  assign len_ok   = (bus.len_data != '0)
                 && (32'(bus.len_data) <= DEPTH);
  assign addr_ok  = (32'(bus.cfg_addr) < DEPTH);

  assign tmr_run     = (state_q == TRACK);
  assign tmr_restart = bus.in_valid || bus.clear;

  seq_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .run     (tmr_run),
    .restart (tmr_restart),
    .expire  (expire)
  );

  // Table writes land after this cycle's compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++)
        tbl_q[i] <= '0;
    end else if (cfg_ok && bus.cfg_we && addr_ok) begin
      tbl_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // Length register; zero or oversize lengths are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      len_q <= PW'(DEPTH);
    else if (cfg_ok && bus.len_we && len_ok)
      len_q <= bus.len_data;
  end

  // Next state: clear, then code input, then idle expiry.
  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    tout_d  = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      prog_d  = '0;
    end else begin
      unique case (state_q)
        IDLE, TRACK: begin
          if (bus.in_valid) begin
            unique case (1'b1)
              hit: begin
                prog_d  = prog_inc;
                state_d = (prog_inc == len_q)
                        ? MATCH : TRACK;
              end
              !hit && RESTART_ON_MISS && hit0: begin
                prog_d  = PW'(1);
                state_d = (len_q == PW'(1))
                        ? MATCH : TRACK;
              end
              !hit && RESTART_ON_MISS && !hit0: begin
                prog_d  = '0;
                state_d = IDLE;
              end
              !hit && !RESTART_ON_MISS: begin
                state_d = ERROR;
              end
            endcase
          end else if (expire) begin
            state_d = IDLE;
            prog_d  = '0;
            tout_d  = 1'b1;
          end
        end
        MATCH, ERROR: ;
      endcase
    end
  end

  // FSM register with registered result flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prog_q  <= '0;
      match_q <= 1'b0;
      error_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      match_q <= (state_d == MATCH);
      error_q <= (state_d == ERROR);
      tout_q  <= tout_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.progress = prog_q;
  assign bus.match    = match_q;
  assign bus.error    = error_q;
  assign bus.timeout  = tout_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench: two detectors (restart / sticky
// error) driven in parallel against a sequence model.
module tb_moore_seq_detector;
  import moore_seq_pkg::*;

  localparam int CW = 8;
  localparam int D  = 8;
  localparam int T  = 4;

  typedef struct {
    int who;
    int st;
    int prog;
    int m;
    int e;
    int to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          clr;
  logic [7:0]    code;
  logic          vld;
  logic          cwe;
  logic [2:0]    caddr;
  logic [7:0]    cdata;
  logic          lwe;
  logic [3:0]    ldata;

  moore_seq_detector_if #(.CODE_W(CW), .DEPTH(D)) ifa ();
  moore_seq_detector_if #(.CODE_W(CW), .DEPTH(D)) ifb ();

  assign ifa.clear = clr;    assign ifb.clear = clr;
  assign ifa.in_code = code; assign ifb.in_code = code;
  assign ifa.in_valid = vld; assign ifb.in_valid = vld;
  assign ifa.cfg_we = cwe;   assign ifb.cfg_we = cwe;
  assign ifa.cfg_addr = caddr; assign ifb.cfg_addr = caddr;
  assign ifa.cfg_data = cdata; assign ifb.cfg_data = cdata;
  assign ifa.len_we = lwe;   assign ifb.len_we = lwe;
  assign ifa.len_data = ldata; assign ifb.len_data = ldata;

  moore_seq_detector #(
    .CODE_W(CW), .DEPTH(D), .TIMEOUT(T),
    .RESTART_ON_MISS(1'b1)
  ) u_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  moore_seq_detector #(
    .CODE_W(CW), .DEPTH(D), .TIMEOUT(T),
    .RESTART_ON_MISS(1'b0)
  ) u_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  // Reference model, one copy per DUT (0: restart, 1: sticky).
  int mt    [2][D];
  int mlen  [2];
  int mprog [2];
  bit mdone [2];
  bit merr  [2];
  int midle [2];
  bit mto   [2];

  int rtab [7] = '{8'h80, 8'hF8, 8'hC0, 8'hDC,
                   8'hEA, 8'hCE, 8'hE3};

  task automatic check(input string nm, input int act,
                       input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  function automatic int mstate(input int k);
    if (merr[k])       return 3;
    if (mdone[k])      return 2;
    if (mprog[k] > 0)  return 1;
    return 0;
  endfunction

  task automatic model_reset(input int k);
    for (int i = 0; i < D; i++) mt[k][i] = 0;
    mlen[k] = D; mprog[k] = 0; mdone[k] = 0;
    merr[k] = 0; midle[k] = 0; mto[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit idle_before;
    if (!rst) begin
      model_reset(k);
      return;
    end
    idle_before = (mstate(k) == 0);
    mto[k] = 0;
    if (clr) begin
      mprog[k] = 0; mdone[k] = 0;
      merr[k] = 0; midle[k] = 0;
    end else if (!mdone[k] && !merr[k]) begin
      if (vld) begin
        midle[k] = 0;
        if (int'(code) == mt[k][mprog[k]]) begin
          mprog[k]++;
          if (mprog[k] == mlen[k]) mdone[k] = 1;
        end else if (k == 0) begin
          if (int'(code) == mt[k][0]) begin
            mprog[k] = 1;
            if (mlen[k] == 1) mdone[k] = 1;
          end else begin
            mprog[k] = 0;
          end
        end else begin
          merr[k] = 1;
        end
      end else if (mprog[k] > 0) begin
        midle[k]++;
        if (midle[k] == T) begin
          mprog[k] = 0; midle[k] = 0; mto[k] = 1;
        end
      end
    end
    if (idle_before) begin
      if (cwe) mt[k][caddr] = int'(cdata);
      if (lwe && ldata >= 1 && int'(ldata) <= D)
        mlen[k] = int'(ldata);
    end
  endtask

  // One clock: model follows the edge, expectations queued.
  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      q.push_back('{k, mstate(k), mprog[k],
                    int'(mdone[k] && !merr[k]),
                    int'(merr[k]), int'(mto[k])});
    end
    #1;
  endtask

  task automatic idle_in();
    clr = 0; vld = 0; code = '0; cwe = 0;
    caddr = '0; cdata = '0; lwe = 0; ldata = '0;
  endtask

  task automatic feed(input logic [7:0] c);
    idle_in(); vld = 1; code = c; cycle(); idle_in();
  endtask

  task automatic do_clear();
    idle_in(); clr = 1; cycle(); idle_in();
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      string n;
      e = q.pop_front();
      n = e.who ? "B" : "A";
      if (e.who == 0) begin
        check({n, ".state"}, int'(ifa.state), e.st);
        check({n, ".prog"}, int'(ifa.progress), e.prog);
        check({n, ".match"}, int'(ifa.match), e.m);
        check({n, ".error"}, int'(ifa.error), e.e);
        check({n, ".tout"}, int'(ifa.timeout), e.to);
      end else begin
        check({n, ".state"}, int'(ifb.state), e.st);
        check({n, ".prog"}, int'(ifb.progress), e.prog);
        check({n, ".match"}, int'(ifb.match), e.m);
        check({n, ".error"}, int'(ifb.error), e.e);
        check({n, ".tout"}, int'(ifb.timeout), e.to);
      end
    end
  end

  initial begin
    idle_in();
    rst = 0;
    model_reset(0);
    model_reset(1);
    cycle(); cycle();
    settle();
    check("rst_state", int'(ifa.state), 0);
    check("rst_prog", int'(ifb.progress), 0);
    rst = 1;

    // Program the 7-code sequence into both detectors.
    for (int i = 0; i < 7; i++) begin
      idle_in(); cwe = 1; caddr = 3'(i);
      cdata = 8'(rtab[i]); cycle();
    end
    idle_in(); lwe = 1; ldata = 4'd7; cycle(); idle_in();

    // Full match.
    for (int i = 0; i < 7; i++) feed(8'(rtab[i]));
    settle();
    check("full_state", int'(ifa.state), 2);
    check("full_prog", int'(ifa.progress), 7);
    check("full_match", int'(ifb.match), 1);
    do_clear();

    // Restart on miss vs sticky error.
    feed(8'h80); feed(8'hF8); feed(8'h80);
    feed(8'hF8); feed(8'hC0);
    settle();
    check("rsm_prog", int'(ifa.progress), 3);
    check("rsm_state", int'(ifa.state), 1);
    check("stk_state", int'(ifb.state), 3);
    do_clear();

    feed(8'h80); feed(8'hF1);
    settle();
    check("err_flag", int'(ifb.error), 1);
    check("err_prog", int'(ifb.progress), 1);
    feed(8'hF8);
    settle();
    check("err_hold", int'(ifb.progress), 1);
    do_clear();
    settle();
    check("clr_state", int'(ifb.state), 0);

    // Idle timeout.
    feed(8'h80);
    repeat (3) cycle();
    settle();
    check("pre_to", int'(ifa.timeout), 0);
    cycle();
    settle();
    check("to_pulse", int'(ifa.timeout), 1);
    check("to_state", int'(ifb.state), 0);
    cycle();
    settle();
    check("to_once", int'(ifa.timeout), 0);

    // Config dropped outside IDLE; bad length dropped.
    feed(8'h80);
    idle_in(); cwe = 1; caddr = 0; cdata = 8'h55;
    cycle(); idle_in();
    do_clear();
    feed(8'h80);
    settle();
    check("cfg_drop", int'(ifa.progress), 1);
    do_clear();
    idle_in(); lwe = 1; ldata = 4'd0; cycle();
    idle_in(); lwe = 1; ldata = 4'd9; cycle(); idle_in();
    for (int i = 0; i < 7; i++) feed(8'(rtab[i]));
    settle();
    check("len_keep", int'(ifa.match), 1);
    do_clear();

    // Same-cycle write compares against the old entry.
    idle_in(); vld = 1; code = 8'h80;
    cwe = 1; caddr = 0; cdata = 8'h11; cycle(); idle_in();
    settle();
    check("wr_old", int'(ifa.progress), 1);
    do_clear();
    feed(8'h80);
    settle();
    check("wr_new", int'(ifa.progress), 0);
    idle_in(); cwe = 1; caddr = 0; cdata = 8'h80;
    cycle(); idle_in();

    // Asynchronous reset mid-sequence.
    feed(8'h80); feed(8'hF8); feed(8'hC0);
    settle();
    check("pre_rst", int'(ifa.progress), 3);
    #2 rst = 0;
    #1;
    check("arst_state", int'(ifa.state), 0);
    check("arst_prog", int'(ifa.progress), 0);
    cycle();
    rst = 1;
    feed(8'h80);
    settle();
    check("post_rst_p", int'(ifa.progress), 0);
    check("post_rst_s", int'(ifa.state), 0);

    // Reprogram and run random traffic.
    for (int i = 0; i < 7; i++) begin
      idle_in(); clr = 1; cwe = 1; caddr = 3'(i);
      cdata = 8'(rtab[i]); cycle();
    end
    idle_in(); lwe = 1; ldata = 4'd7; cycle();
    for (int n = 0; n < 3000; n++) begin
      idle_in();
      vld = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) == 0)
        code = 8'($urandom);
      else
        code = 8'(rtab[$urandom_range(0, 6)]);
      clr = ($urandom_range(0, 39) == 0);
      cwe = ($urandom_range(0, 19) == 0);
      caddr = 3'($urandom);
      cdata = 8'(rtab[$urandom_range(0, 6)]);
      lwe = ($urandom_range(0, 29) == 0);
      ldata = 4'($urandom_range(0, 9));
      cycle();
    end
    idle_in();
    repeat (2) settle();
    check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Parametrised, programmable Moore sequence detector: the successor to our fixed 8-bit code-word state machine. It accepts a stream of CODE_W-bit code words and tracks progress through a run-time-programmed sequence of up to DEPTH codes. It flags a completed match or a miss, and abandons a partial sequence after an inactivity timeout. All outputs are registered and depend only on state. The block sits between the code-word source and downstream logic that consumes the match/error result.

## Interface
- CODE_W, 8, code word width
- DEPTH, 8, maximum sequence length (>=1)
- TIMEOUT, 16, idle cycles in TRACK before abandoning; 0 disables
- RESTART_ON_MISS, 1, 1: a miss restarts matching; 0: a miss goes to sticky ERROR
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous return to IDLE; the table is kept
- in_code  in  CODE_W  code word
- in_valid  in  1  in_code is sampled this cycle
- cfg_we  in  1  write cfg_data into table[cfg_addr]
- cfg_addr  in  $clog2(DEPTH)  table index
- cfg_data  in  CODE_W  code value
- len_we  in  1  write len_data into the length register
- len_data  in  $clog2(DEPTH+1)  sequence length
- state  out  2  IDLE=00, TRACK=01, MATCH=10, ERROR=11
- progress  out  $clog2(DEPTH+1)  codes matched so far
- match  out  1  state==MATCH
- error  out  1  state==ERROR
- timeout  out  1  one-cycle pulse when a partial sequence is abandoned

## Operation
- Reset (rst=0, asynchronous):
  - state=IDLE, progress=0, match=0, error=0, timeout=0.
  - All table entries=0, len=DEPTH, timer=0.
- Configuration is accepted only in IDLE:
  - cfg_we or len_we in any other state is dropped silently.
  - A len_we with len_data=0 or len_data>DEPTH is dropped.
- In IDLE or TRACK, with in_valid=1:
  - Hit, in_code==table[progress]: progress+1. State becomes MATCH if progress+1==len, else TRACK.
  - Miss with RESTART_ON_MISS=1: if in_code==table[0], progress=1 (state MATCH if len==1, else TRACK). Otherwise progress=0 and state IDLE.
  - Miss with RESTART_ON_MISS=0: state ERROR; progress holds its value at the miss.
- MATCH and ERROR are sticky. in_valid is ignored in both; only clear or rst leaves them.
- clear: state=IDLE, progress=0, timer=0. The table and len are kept.
- Timeout, TIMEOUT>0:
  - The timer counts cycles spent in TRACK with in_valid=0.
  - The timer resets on every in_valid, on every state change, and outside TRACK.
  - When the timer reaches TIMEOUT: state=IDLE, progress=0, timeout=1 for exactly one cycle.
- Priority: rst > clear > in_valid > timeout expiry.
- cfg_we together with in_valid in IDLE: the comparison uses the old entry; the new value applies from the next cycle.
- cfg_data writes to an address >= len are legal but unused.

## Timing
- in_valid sampled at edge n: state, progress, match and error reflect it after edge n (1-cycle latency).
- A sequence of L codes on consecutive cycles gives match=1 at edge L, earliest.
- timeout asserts in the cycle after the edge on which the timer reaches TIMEOUT. It is a single-cycle pulse.
- rst asserted mid-sequence: all outputs go to reset values immediately, without waiting for a clock. Deassertion is synchronised externally.

## Structure
- Package moore_seq_pkg:
  - state_t enum with the encodings IDLE/TRACK/MATCH/ERROR.
  - Default CODE_W, DEPTH and TIMEOUT constants.
- Sub-module seq_timeout_counter:
  - Parameter TIMEOUT; inputs run and restart; output expire.
  - Tied off (expire=0) when TIMEOUT=0.
- The top module holds the code table (register array), the len register and the state register.

## Test plan
- Program len=7, table = 80,F8,C0,DC,EA,CE,E3 (hex). Feed those 7 codes -> match=1 after the 7th edge, state=10, progress=7.
- Same table, RESTART_ON_MISS=1. Feed 80,F8,80,F8,C0 -> the third code (80) restarts with progress=1; after the last code, progress=3, state=TRACK.
- RESTART_ON_MISS=0. Feed 80 then F1 -> state=ERROR, error=1, progress=1. A further in_valid is ignored. clear -> IDLE, progress=0.
- TIMEOUT=4. Feed 80, then in_valid=0 for 4 cycles -> timeout pulses once, state=IDLE, progress=0.
- In TRACK, cfg_we to address 0 -> table unchanged. len_we with len_data=0 in IDLE -> len stays 7.
- Assert rst mid-sequence (progress=3) -> immediately state=00, progress=0. After release, feeding 80 once gives progress=0 and state IDLE, because the table was cleared to 0 and len=DEPTH=8.
